multibit_bch_encoder: RTL and testbench

- Parametrised systematic cyclic/BCH encoder. Processes P message bits per clock through a generator-polynomial LFSR. Supports shortened codes and an arbitrary generator polynomial.
- Valid/ready handshakes on both input and output, so it sits between a message source and the channel interleaver/modulator with full backpressure.
- Successor to the fixed BCH(15,7) serial/parallel encoders. The defaults reproduce BCH(15,7), t=2.

---
 rtl/bch_pkg.sv | 22 ++
 rtl/multibit_bch_encoder_if.sv | 15 +
 rtl/bch_lfsr_chunk.sv | 23 ++
 rtl/multibit_bch_encoder.sv | 72 +++++++
 tb/tb_multibit_bch_encoder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bch_pkg.sv
// bch_pkg: shared BCH code constants, FSM state type and the single-bit LFSR step
package bch_pkg;
   localparam int MAX_R = 64;
   localparam int BCH15_N = 15;
   localparam int BCH15_K = 7;
   localparam logic [8:0] BCH15_GEN = 9'b111010001;
   localparam int BCH31_N = 31;
   localparam int BCH31_K = 21;
   localparam logic [10:0] BCH31_GEN = 11'b11101101001;

   typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

   // r is the live register width; bits above it are kept at zero
   function automatic logic [MAX_R-1:0] lfsr_step(input logic [MAX_R-1:0] lfsr, input logic b,
                                                  input logic [MAX_R-1:0] gen, input int r);
      logic fb;
      logic [MAX_R-1:0] mask;
      fb = lfsr[r-1] ^ b;
      mask = (MAX_R'(1) << r) - MAX_R'(1);
      return ((lfsr << 1) ^ (fb ? gen : '0)) & mask;
   endfunction
endpackage

// File: rtl/multibit_bch_encoder_if.sv
// multibit_bch_encoder_if: message-in / codeword-out valid-ready streams
interface multibit_bch_encoder_if #(
   parameter int V = 7,
   parameter int W = 15
);
   logic in_valid;
   logic in_ready;
   logic [V-1:0] data_in;
   logic out_valid;
   logic out_ready;
   logic [W-1:0] codeword_out;

   modport slave (input in_valid, data_in, out_ready, output in_ready, out_valid, codeword_out);
   modport master (output in_valid, data_in, out_ready, input in_ready, out_valid, codeword_out);
endinterface

// File: rtl/bch_lfsr_chunk.sv
// bch_lfsr_chunk: P unrolled generator-polynomial LFSR steps, bits[P-1] absorbed first
module bch_lfsr_chunk
   import bch_pkg::*;
#(
   parameter int R = 8,
   parameter int P = 1,
   parameter logic [R:0] GEN = 9'b111010001
) (
   input  logic [R-1:0] lfsr_in,
   input  logic [P-1:0] bits,
   output logic [R-1:0] lfsr_out
);
   logic [MAX_R-1:0] s;
   logic unused_hi;

   always_comb begin
      s = MAX_R'(lfsr_in);
      for (int i = P - 1; i >= 0; i--) s = lfsr_step(s, bits[i], MAX_R'(GEN[R-1:0]), R);
      lfsr_out = s[R-1:0];
   end

   assign unused_hi = ^s[MAX_R-1:R];
endmodule

// File: rtl/multibit_bch_encoder.sv
// multibit_bch_encoder: systematic cyclic/BCH encoder absorbing P message bits per clock
module multibit_bch_encoder
   import bch_pkg::*;
#(
   parameter int N = BCH15_N,
   parameter int K = BCH15_K,
   parameter logic [N-K:0] GEN = BCH15_GEN,
   parameter int SHORTEN = 0,
   parameter int P = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic busy,
   multibit_bch_encoder_if.slave bus
);
   localparam int R = N - K;
   localparam int V = K - SHORTEN;
   localparam int STEPS = V / P;
   localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;

   if (V % P != 0) begin : g_bad_p
      $error("P must divide the shortened message length");
   end
   if (!GEN[0] || !GEN[R] || R >= MAX_R) begin : g_bad_gen
      $error("generator polynomial must have x^0 and x^(N-K) terms");
   end

   state_t state;
   logic [R-1:0] lfsr;
   logic [R-1:0] lfsr_next;
   logic [V-1:0] msg;
   logic [CW-1:0] cnt;
   logic [P-1:0] chunk;
   logic accept;

   assign bus.in_ready = reset && (state == IDLE || (state == HOLD && bus.out_ready));
   assign bus.out_valid = state == HOLD;
   assign bus.codeword_out = {msg, lfsr};
   assign busy = state == ENCODE;
   assign accept = bus.in_valid && bus.in_ready && en;
   // counter doubles as the chunk index, highest chunk first
   assign chunk = msg[cnt*P +: P];

   bch_lfsr_chunk #(.R(R), .P(P), .GEN(GEN)) u_chunk (
      .lfsr_in(lfsr),
      .bits(chunk),
      .lfsr_out(lfsr_next)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         lfsr <= '0;
         msg <= '0;
         cnt <= '0;
      end else if (en) begin
         if (accept) begin
            state <= ENCODE;
            msg <= bus.data_in;
            lfsr <= '0;
            cnt <= CW'(STEPS - 1);
         end else if (state == ENCODE) begin
            lfsr <= lfsr_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= HOLD;
         end else if (state == HOLD && bus.out_ready) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_multibit_bch_encoder.sv
// tb_multibit_bch_encoder: scoreboard bench over P=1, P=7 and shortened P=5 encoders
module tb_multibit_bch_encoder;
   logic clk = 0;
   logic reset = 1;
   logic en = 1;
   logic busy1, busy7, busy5;
   int checks = 0;
   int errors = 0;
   logic [14:0] q1[$];
   logic [14:0] q7[$];
   logic [12:0] q5[$];

   typedef struct {
      logic [6:0] msg;
      logic [14:0] cw;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   multibit_bch_encoder_if #(.V(7), .W(15)) b1 ();
   multibit_bch_encoder_if #(.V(7), .W(15)) b7 ();
   multibit_bch_encoder_if #(.V(5), .W(13)) b5 ();

   multibit_bch_encoder u1 (.clk(clk), .reset(reset), .en(en), .busy(busy1), .bus(b1));
   multibit_bch_encoder #(.P(7)) u7 (.clk(clk), .reset(reset), .en(en), .busy(busy7), .bus(b7));
   multibit_bch_encoder #(.SHORTEN(2), .P(5)) u5 (.clk(clk), .reset(reset), .en(en), .busy(busy5), .bus(b5));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // polynomial long division of m(x)*x^8 by g(x)
   function automatic logic [14:0] ref15(input logic [6:0] m);
      logic [14:0] v;
      v = {m, 8'h00};
      for (int i = 14; i >= 8; i--) if (v[i]) v = v ^ (15'h1D1 << (i - 8));
      return {m, v[7:0]};
   endfunction

   always @(negedge clk) begin
      if (reset && en && b1.out_valid && b1.out_ready) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1_unexpected actual=%0h required=none", b1.codeword_out);
         end else chk("u1_codeword", 32'(b1.codeword_out), 32'(q1.pop_front()));
      end
      if (reset && en && b7.out_valid && b7.out_ready) begin
         if (q7.size() == 0) begin
            checks++; errors++;
            $display("FAIL u7_unexpected actual=%0h required=none", b7.codeword_out);
         end else chk("u7_codeword", 32'(b7.codeword_out), 32'(q7.pop_front()));
      end
      if (reset && en && b5.out_valid && b5.out_ready) begin
         if (q5.size() == 0) begin
            checks++; errors++;
            $display("FAIL u5_unexpected actual=%0h required=none", b5.codeword_out);
         end else chk("u5_codeword", 32'(b5.codeword_out), 32'(q5.pop_front()));
      end
   end

   task automatic run1(input logic [6:0] m, input logic [14:0] exp);
      int lat = 0;
      chk("u1_in_ready", 32'(b1.in_ready), 1);
      b1.data_in = m; b1.in_valid = 1; q1.push_back(exp);
      @(posedge clk); #1; b1.in_valid = 0;
      while (!b1.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("u1_latency", 32'(lat), 7);
      @(posedge clk); #1;
   endtask

   task automatic run7(input logic [6:0] m, input logic [14:0] exp);
      int lat = 0;
      chk("u7_in_ready", 32'(b7.in_ready), 1);
      b7.data_in = m; b7.in_valid = 1; q7.push_back(exp);
      @(posedge clk); #1; b7.in_valid = 0;
      while (!b7.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("u7_latency", 32'(lat), 1);
      @(posedge clk); #1;
   endtask

   task automatic run5(input logic [4:0] m, input logic [12:0] exp);
      int lat = 0;
      b5.data_in = m; b5.in_valid = 1; q5.push_back(exp);
      @(posedge clk); #1; b5.in_valid = 0;
      while (!b5.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("u5_latency", 32'(lat), 1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [6:0] m;
      logic [4:0] m5;
      logic [14:0] r;
      int lat;
      tbl[0] = '{7'b1000000, 15'h40E8};
      tbl[1] = '{7'b0000001, 15'h01D1};
      tbl[2] = '{7'b0000000, 15'h0000};
      tbl[3] = '{7'b1000001, 15'h4139};
      b1.in_valid = 0; b7.in_valid = 0; b5.in_valid = 0;
      b1.data_in = '0; b7.data_in = '0; b5.data_in = '0;
      b1.out_ready = 1; b7.out_ready = 1; b5.out_ready = 1;
      #2 reset = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(b1.out_valid), 0);
      chk("rst_busy", 32'({busy1, busy7, busy5}), 0);
      chk("rst_codeword", 32'(b1.codeword_out), 0);
      chk("rst_codeword7", 32'(b7.codeword_out), 0);
      reset = 1;
      #1;
      chk("rel_in_ready", 32'({b1.in_ready, b7.in_ready, b5.in_ready}), 32'h7);
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) begin
         run1(tbl[i].msg, tbl[i].cw);
         run7(tbl[i].msg, tbl[i].cw);
      end
      repeat (4) begin
         m = 7'($urandom);
         run1(m, ref15(m));
         run7(m, ref15(m));
      end
      run5(5'b00001, 13'h01D1);
      m5 = 5'($urandom);
      r = ref15({2'b00, m5});
      run5(m5, r[12:0]);

      // backpressure then same-edge accept of the next message
      b1.out_ready = 0;
      b1.data_in = 7'b1000000; b1.in_valid = 1; q1.push_back(15'h40E8);
      @(posedge clk); #1; b1.in_valid = 0;
      lat = 0;
      while (!b1.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("bp_latency", 32'(lat), 7);
      repeat (10) begin
         @(posedge clk); #1;
         chk("bp_codeword", 32'(b1.codeword_out), 32'h40E8);
         chk("bp_in_ready", 32'(b1.in_ready), 0);
         chk("bp_out_valid", 32'(b1.out_valid), 1);
      end
      b1.out_ready = 1; b1.data_in = 7'b0000001; b1.in_valid = 1; q1.push_back(15'h01D1);
      #1;
      chk("b2b_in_ready", 32'(b1.in_ready), 1);
      @(posedge clk); #1; b1.in_valid = 0;
      chk("b2b_out_valid_drop", 32'(b1.out_valid), 0);
      chk("b2b_busy", 32'(busy1), 1);
      lat = 0;
      while (!b1.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("b2b_latency", 32'(lat), 7);
      @(posedge clk); #1;

      // clock enable low on alternate encode cycles, then held low in HOLD
      b1.data_in = 7'b1000000; b1.in_valid = 1; q1.push_back(15'h40E8);
      @(posedge clk); #1; b1.in_valid = 0; en = 0;
      lat = 0;
      while (!b1.out_valid && lat < 100) begin @(posedge clk); #1; lat++; en = ~en; end
      chk("en_latency", 32'(lat), 14);
      en = 0;
      repeat (3) begin @(posedge clk); #1; chk("en_hold_valid", 32'(b1.out_valid), 1); end
      en = 1;
      @(posedge clk); #1;
      chk("en_released_idle", 32'(b1.out_valid), 0);

      // asynchronous reset in the third encode cycle
      b1.data_in = 7'b1000001; b1.in_valid = 1;
      @(posedge clk); #1; b1.in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy1), 1);
      reset = 0;
      #1;
      chk("mid_rst_out_valid", 32'(b1.out_valid), 0);
      chk("mid_rst_busy", 32'(busy1), 0);
      chk("mid_rst_codeword", 32'(b1.codeword_out), 0);
      #2 reset = 1;
      #1;
      chk("mid_rel_in_ready", 32'(b1.in_ready), 1);
      repeat (10) @(posedge clk);
      #1;
      chk("mid_no_stale", 32'(b1.out_valid), 0);
      run1(7'b1000000, 15'h40E8);

      repeat (3) @(posedge clk);
      #1;
      chk("q1_drained", 32'(q1.size()), 0);
      chk("q7_drained", 32'(q7.size()), 0);
      chk("q5_drained", 32'(q5.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
